calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Control FSM between the PS/2 scancode stream and an external multi-cycle arithmetic unit of the calculator.
- Decodes make codes into digit/operator/enter/clear events and builds operands A and B in both binary and BCD.
- Issues start/done-handshaked ALU requests and converts binary results to BCD through an iterative sub-module.
- Drives the 6-digit BCD display bus consumed by the seven-segment LUTs.

Parameters:
- DIGITS, 6, maximum decimal digits per operand and on the display
- WIDTH, 20, binary operand/result width (holds 999999)
- MAXVAL, 999999, largest legal operand/result

Ports:
- clk  input  1  system clock (divided clock)
- iRST_n  input  1  asynchronous active-low reset
- iKEY_VALID  input  1  one-cycle pulse; iKEY_CODE holds a new scancode byte
- iKEY_CODE  input  8  raw PS/2 set-2 byte
- oALU_START  output  1  one-cycle request pulse
- oALU_OP  output  2  00 add, 01 sub, 10 mul, 11 div
- oALU_A  output  WIDTH  left operand, stable from START until DONE
- oALU_B  output  WIDTH  right operand, stable from START until DONE
- iALU_DONE  input  1  one-cycle pulse; result valid
- iALU_RESULT  input  WIDTH+4  unsigned result (extra bits expose overflow)
- iALU_ERR  input  1  divide-by-zero or negative result, qualified by iALU_DONE
- oDISP  output  4*DIGITS  BCD display, digit 0 in [3:0]
- oERR  output  1  error latched
- oBUSY  output  1  high in ALU_REQ, ALU_WAIT, CONVERT

Behaviour:
- Reset (iRST_n asynchronous, active-low; clock clk):
  - state ENTRY_A; all outputs 0; operands, BCD registers and digit count 0; prefix flags clear.
  - Reset mid-ALU or mid-conversion aborts; a later iALU_DONE is ignored.
- Prefix handling:
  - E0 sets ext flag, consumed by the next byte.
  - F0 sets brk flag; the next byte is discarded and clears both flags.
- Make-code events (only when iKEY_VALID and not oBUSY; bytes received while busy are dropped, including prefixes):
  - digit: 70,69,72,7A,6B,73,74,6C,75,7D = 0..9
  - operator: 79 add, 7B sub, 7C mul, 4A div (ext or not)
  - enter: 5A (ext or not)
  - clear: 76
  - all other codes ignored.
- Digit entry on the current operand:
  - bin <= bin*10+d; bcd <= {bcd[19:0],d}; cnt++.
  - Digit ignored when cnt==DIGITS.
  - Leading zero with cnt==0 and d==0 keeps cnt 0.
  - oDISP shows the operand being entered.
- States and transitions:
  - ENTRY_A
    - digit: enter into A.
    - operator: latch op, go OP_WAIT; display keeps A.
    - enter: no-op.
  - OP_WAIT
    - operator: replaces op.
    - digit: clear B, enter digit, go ENTRY_B.
    - enter: B:=A, go ALU_REQ.
  - ENTRY_B
    - digit: enter into B.
    - operator: go ALU_REQ with chain flag set and new op saved as pending.
    - enter: go ALU_REQ with chain flag clear.
  - ALU_REQ: assert oALU_START for exactly 1 cycle, go ALU_WAIT.
  - ALU_WAIT
    - wait for iALU_DONE.
    - If iALU_ERR, or result > MAXVAL, go ERROR.
    - Otherwise A := result, start converter, go CONVERT.
  - CONVERT
    - Wait for converter done; load A BCD and oDISP.
    - If chain: op := pending, go OP_WAIT.
    - Else go RESULT.
  - RESULT
    - digit: A cleared, digit entered, go ENTRY_A.
    - operator: uses result as A, go OP_WAIT.
    - enter: no-op.
  - ERROR
    - oERR=1, oDISP=all 4'hE.
    - Only clear leaves ERROR.
- Clear in any non-busy state: everything to reset values, state ENTRY_A.
- Latency: DONE to display is WIDTH+2 cycles.

Decomposition:
- Package calc_pkg holds:
  - op encodings
  - state enum
  - scancode constants (digits, operators, 5A, 76, E0, F0)
  - DIGITS, WIDTH, MAXVAL
- Sub-module bin2bcd_seq: iterative double-dabble with start/done handshake, WIDTH shift cycles plus 1 load cycle, output 4*DIGITS.

Test Plan:
- 69,72,7A -> oDISP=0x000123; F0,69 break pair -> no change.
- 7D,79,72,5A, DONE with result 11 -> oALU_OP=00, A=9, B=2, oDISP=0x000011 after WIDTH+2 cycles.
- 75,7B,7A,7C,72,5A -> first request sub 8-3; result 5 shows and state OP_WAIT; second request mul 5*2 -> 0x000010.
- 7A,E0,4A,70,E0,5A, ALU returns DONE with ERR -> oERR=1, oDISP=0xEEEEEE; digits ignored; 76 -> all zero.
- Seven 69 presses -> oDISP=0x111111 (seventh digit ignored); keys pressed while oBUSY=1 -> dropped.
- Reset asserted in ALU_WAIT -> state ENTRY_A; a subsequent iALU_DONE produces no display change.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants, types and helpers for the calculator sequencer.
// Holds sizes, ALU op codes, FSM states, PS/2 set-2 scancodes and BCD helpers.
package calc_pkg;

    localparam int DIGITS = 6;
    localparam int WIDTH  = 20;
    localparam int MAXVAL = 999999;
    localparam int BCDW   = 4 * DIGITS;
    localparam int RESW   = WIDTH + 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ENTRY_A,
        OP_WAIT,
        ENTRY_B,
        ALU_REQ,
        ALU_WAIT,
        CONVERT,
        RESULT,
        ERROR
    } state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_CLEAR = 8'h76;
    localparam logic [7:0] SC_ADD   = 8'h79;
    localparam logic [7:0] SC_SUB   = 8'h7B;
    localparam logic [7:0] SC_MUL   = 8'h7C;
    localparam logic [7:0] SC_DIV   = 8'h4A;
    localparam logic [7:0] SC_D0    = 8'h70;
    localparam logic [7:0] SC_D1    = 8'h69;
    localparam logic [7:0] SC_D2    = 8'h72;
    localparam logic [7:0] SC_D3    = 8'h7A;
    localparam logic [7:0] SC_D4    = 8'h6B;
    localparam logic [7:0] SC_D5    = 8'h73;
    localparam logic [7:0] SC_D6    = 8'h74;
    localparam logic [7:0] SC_D7    = 8'h6C;
    localparam logic [7:0] SC_D8    = 8'h75;
    localparam logic [7:0] SC_D9    = 8'h7D;

    // Returns {hit, value}.
    function automatic logic [4:0] decodeDigit(input logic [7:0] c);
        case (c)
            SC_D0:   return 5'h10;
            SC_D1:   return 5'h11;
            SC_D2:   return 5'h12;
            SC_D3:   return 5'h13;
            SC_D4:   return 5'h14;
            SC_D5:   return 5'h15;
            SC_D6:   return 5'h16;
            SC_D7:   return 5'h17;
            SC_D8:   return 5'h18;
            SC_D9:   return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    // Returns {hit, op}.
    function automatic logic [2:0] decodeOp(input logic [7:0] c);
        case (c)
            SC_ADD:  return {1'b1, OP_ADD};
            SC_SUB:  return {1'b1, OP_SUB};
            SC_MUL:  return {1'b1, OP_MUL};
            SC_DIV:  return {1'b1, OP_DIV};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] timesTenPlus(
        input logic [WIDTH-1:0] v,
        input logic [3:0]       d
    );
        return (v << 3) + (v << 1) + WIDTH'(d);
    endfunction

    // Double-dabble correction: add 3 to every digit of 5 or more.
    function automatic logic [BCDW-1:0] dabble(input logic [BCDW-1:0] v);
        logic [BCDW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Start/done request bus between the sequencer and the arithmetic unit.
// master: sequencer (drives START/OP/A/B); slave: ALU (drives DONE/RESULT/ERR).
interface calc_sequencer_if;
    import calc_pkg::*;

    logic             oALU_START;
    logic [1:0]       oALU_OP;
    logic [WIDTH-1:0] oALU_A;
    logic [WIDTH-1:0] oALU_B;
    logic             iALU_DONE;
    logic [RESW-1:0]  iALU_RESULT;
    logic             iALU_ERR;

    modport master (
        output oALU_START, oALU_OP, oALU_A, oALU_B,
        input  iALU_DONE, iALU_RESULT, iALU_ERR
    );

    modport slave (
        input  oALU_START, oALU_OP, oALU_A, oALU_B,
        output iALU_DONE, iALU_RESULT, iALU_ERR
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: 1 load cycle + WIDTH shifts.
// Ports: clk, iRST_n, iStart (load pulse), iBin, oBcd, oDone (1-cycle pulse).
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iBin,
    output logic [BCDW-1:0]  oBcd,
    output logic             oDone
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] binSh;
    logic [CW-1:0]    left;
    logic [BCDW-1:0]  adj;

    assign adj = dabble(oBcd);

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            binSh <= '0;
            oBcd  <= '0;
            left  <= '0;
            oDone <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (iStart) begin
                binSh <= iBin;
                oBcd  <= '0;
                left  <= CW'(WIDTH);
            end else if (left != '0) begin
                oBcd  <= BCDW'({adj, binSh[WIDTH-1]});
                binSh <= binSh << 1;
                left  <= left - CW'(1);
                oDone <= (left == CW'(1));
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: PS/2 make codes -> operands -> ALU -> BCD display.
// Ports: clk, iRST_n, iKEY_VALID/iKEY_CODE, alu (master), oDISP, oERR, oBUSY.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             iRST_n,
    input  logic             iKEY_VALID,
    input  logic [7:0]       iKEY_CODE,
    calc_sequencer_if.master alu,
    output logic [BCDW-1:0]  oDISP,
    output logic             oERR,
    output logic             oBUSY
);

    state_e           state, stateNext;
    logic [1:0]       op, pendOp;
    logic             chain, extFlag, brkFlag;
    logic             convGo, convDone;
    logic [WIDTH-1:0] aBin, bBin;
    logic [BCDW-1:0]  aBcd, bBcd, convBcd;
    logic [2:0]       cnt, cntNext;
    logic [4:0]       dig;
    logic [2:0]       opd;
    logic [3:0]       d;
    logic             keyIn, makeIn, full, resOk;
    logic             evDigit, evOp, evEnter, evClear;

    assign oBUSY = (state == ALU_REQ) || (state == ALU_WAIT)
                || (state == CONVERT);
    assign oERR  = (state == ERROR);

    assign alu.oALU_START = (state == ALU_REQ);
    assign alu.oALU_OP    = op;
    assign alu.oALU_A     = aBin;
    assign alu.oALU_B     = bBin;

    // Bytes arriving while busy are dropped, prefixes included.
    assign keyIn  = iKEY_VALID && !oBUSY;
    assign makeIn = keyIn && !brkFlag
                 && iKEY_CODE != SC_EXT && iKEY_CODE != SC_BRK;
    assign dig    = decodeDigit(iKEY_CODE);
    assign opd    = decodeOp(iKEY_CODE);
    assign d      = dig[3:0];

    assign evDigit = makeIn && !extFlag && dig[4];
    assign evOp    = makeIn && opd[2];
    assign evEnter = makeIn && iKEY_CODE == SC_ENTER;
    assign evClear = makeIn && !extFlag && iKEY_CODE == SC_CLEAR;

    assign full    = (cnt == 3'(DIGITS));
    assign cntNext = (cnt == 3'd0 && d == 4'd0) ? cnt : cnt + 3'd1;
    assign resOk   = !alu.iALU_ERR && alu.iALU_RESULT <= RESW'(MAXVAL);

    bin2bcd_seq uConv (
        .clk    (clk),
        .iRST_n (iRST_n),
        .iStart (convGo),
        .iBin   (aBin),
        .oBcd   (convBcd),
        .oDone  (convDone)
    );

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) state <= ENTRY_A;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ENTRY_A:  if (evOp) stateNext = OP_WAIT;
            OP_WAIT:  begin
                if (evDigit)      stateNext = ENTRY_B;
                else if (evEnter) stateNext = ALU_REQ;
            end
            ENTRY_B:  if (evOp || evEnter) stateNext = ALU_REQ;
            ALU_REQ:  stateNext = ALU_WAIT;
            ALU_WAIT: if (alu.iALU_DONE) stateNext = resOk ? CONVERT : ERROR;
            CONVERT:  if (convDone) stateNext = chain ? OP_WAIT : RESULT;
            RESULT:   begin
                if (evDigit)   stateNext = ENTRY_A;
                else if (evOp) stateNext = OP_WAIT;
            end
            default:  stateNext = state;
        endcase
        if (evClear) stateNext = ENTRY_A;
    end

    always_comb begin
        oDISP = aBcd;
        case (state)
            ENTRY_B, ALU_REQ, ALU_WAIT, CONVERT: oDISP = bBcd;
            ERROR:   oDISP = {DIGITS{4'hE}};
            default: oDISP = aBcd;
        endcase
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            op      <= OP_ADD;
            pendOp  <= OP_ADD;
            chain   <= 1'b0;
            extFlag <= 1'b0;
            brkFlag <= 1'b0;
            convGo  <= 1'b0;
            aBin    <= '0;
            bBin    <= '0;
            aBcd    <= '0;
            bBcd    <= '0;
            cnt     <= '0;
        end else begin
            convGo <= 1'b0;
            if (keyIn) begin
                if (brkFlag) begin
                    brkFlag <= 1'b0;
                    extFlag <= 1'b0;
                end else if (iKEY_CODE == SC_EXT) begin
                    extFlag <= 1'b1;
                end else if (iKEY_CODE == SC_BRK) begin
                    brkFlag <= 1'b1;
                end else begin
                    extFlag <= 1'b0;
                end
            end
            if (evClear) begin
                op     <= OP_ADD;
                pendOp <= OP_ADD;
                chain  <= 1'b0;
                aBin   <= '0;
                bBin   <= '0;
                aBcd   <= '0;
                bBcd   <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    ENTRY_A: begin
                        if (evDigit && !full) begin
                            aBin <= timesTenPlus(aBin, d);
                            aBcd <= {aBcd[BCDW-5:0], d};
                            cnt  <= cntNext;
                        end
                        if (evOp) op <= opd[1:0];
                    end
                    OP_WAIT: begin
                        if (evOp) op <= opd[1:0];
                        if (evDigit) begin
                            bBin <= WIDTH'(d);
                            bBcd <= BCDW'(d);
                            cnt  <= (d != 4'd0) ? 3'd1 : 3'd0;
                        end
                        if (evEnter) begin
                            bBin  <= aBin;
                            bBcd  <= aBcd;
                            chain <= 1'b0;
                        end
                    end
                    ENTRY_B: begin
                        if (evDigit && !full) begin
                            bBin <= timesTenPlus(bBin, d);
                            bBcd <= {bBcd[BCDW-5:0], d};
                            cnt  <= cntNext;
                        end
                        if (evOp) begin
                            chain  <= 1'b1;
                            pendOp <= opd[1:0];
                        end
                        if (evEnter) chain <= 1'b0;
                    end
                    ALU_WAIT: begin
                        if (alu.iALU_DONE && resOk) begin
                            aBin   <= alu.iALU_RESULT[WIDTH-1:0];
                            convGo <= 1'b1;
                        end
                    end
                    CONVERT: begin
                        if (convDone) begin
                            aBcd <= convBcd;
                            if (chain) op <= pendOp;
                        end
                    end
                    RESULT: begin
                        if (evDigit) begin
                            aBin <= WIDTH'(d);
                            aBcd <= BCDW'(d);
                            cnt  <= (d != 4'd0) ? 3'd1 : 3'd0;
                        end
                        if (evOp) op <= opd[1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences, ALU responder,
// scoreboard queues for ALU requests and post-conversion display values.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic            clk = 1'b0;
    logic            iRST_n = 1'b0;
    logic            iKEY_VALID = 1'b0;
    logic [7:0]      iKEY_CODE = 8'h00;
    logic [BCDW-1:0] oDISP;
    logic            oERR;
    logic            oBUSY;

    calc_sequencer_if alu();

    calc_sequencer dut (
        .clk        (clk),
        .iRST_n     (iRST_n),
        .iKEY_VALID (iKEY_VALID),
        .iKEY_CODE  (iKEY_CODE),
        .alu        (alu),
        .oDISP      (oDISP),
        .oERR       (oERR),
        .oBUSY      (oBUSY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [41:0]     reqQ[$];
    logic [BCDW-1:0] dispQ[$];
    logic            prevBusy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic req(input logic [1:0] o, input int a, input int b);
        reqQ.push_back({o, 20'(a), 20'(b)});
    endtask

    task automatic key(input logic [7:0] c);
        @(posedge clk); #1;
        iKEY_VALID = 1'b1;
        iKEY_CODE  = c;
        @(posedge clk); #1;
        iKEY_VALID = 1'b0;
    endtask

    task automatic waitAluWait();
        int n;
        n = 0;
        @(negedge clk);
        while (!(oBUSY && !alu.oALU_START) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("alu_wait_reached", {oBUSY, alu.oALU_START}, 2'b10);
    endtask

    task automatic aluReply(input int res, input logic err);
        waitAluWait();
        @(posedge clk); #1;
        alu.iALU_DONE   = 1'b1;
        alu.iALU_RESULT = 24'(res);
        alu.iALU_ERR    = err;
        @(posedge clk); #1;
        alu.iALU_DONE   = 1'b0;
        alu.iALU_RESULT = '0;
        alu.iALU_ERR    = 1'b0;
    endtask

    // Called #1 after the edge that sampled DONE.
    task automatic convLatency();
        repeat (WIDTH + 1) @(posedge clk);
        #1 chk("busy_before_latency", oBUSY, 1'b1);
        @(posedge clk);
        #1 chk("idle_at_latency", oBUSY, 1'b0);
    endtask

    always @(negedge clk) begin
        if (alu.oALU_START) begin
            if (reqQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: op %0h a %0d b %0d",
                         alu.oALU_OP, alu.oALU_A, alu.oALU_B);
            end else begin
                chk("alu_req", {alu.oALU_OP, alu.oALU_A, alu.oALU_B},
                    reqQ.pop_front());
            end
        end
        if (prevBusy && !oBUSY) begin
            if (dispQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_idle: disp %0h", oDISP);
            end else begin
                chk("result_disp", oDISP, dispQ.pop_front());
            end
        end
        prevBusy <= oBUSY;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        alu.iALU_DONE   = 1'b0;
        alu.iALU_RESULT = '0;
        alu.iALU_ERR    = 1'b0;
        repeat (3) @(posedge clk);
        #1 iRST_n = 1'b1;
        chk("rst_disp", oDISP, 0);
        chk("rst_err", oERR, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_start", alu.oALU_START, 0);

        // Digit entry and a break pair.
        key(8'h69); key(8'h72); key(8'h7A);
        chk("entry_123", oDISP, 24'h000123);
        key(8'hF0); key(8'h69);
        chk("break_pair", oDISP, 24'h000123);
        key(8'h76);
        chk("clear_1", oDISP, 0);

        // 9 + 2 = 11.
        key(8'h7D); key(8'h79);
        chk("op_keeps_a", oDISP, 24'h000009);
        key(8'h72);
        chk("entry_b", oDISP, 24'h000002);
        req(OP_ADD, 9, 2);
        dispQ.push_back(24'h000011);
        key(8'h5A);
        aluReply(11, 1'b0);
        convLatency();
        key(8'h76);

        // 8 - 3, chained into * 2.
        req(OP_SUB, 8, 3);
        dispQ.push_back(24'h000005);
        key(8'h75); key(8'h7B); key(8'h7A); key(8'h7C);
        aluReply(5, 1'b0);
        convLatency();
        req(OP_MUL, 5, 2);
        dispQ.push_back(24'h000010);
        key(8'h72); key(8'h5A);
        aluReply(10, 1'b0);
        convLatency();
        key(8'h76);

        // 3 / 0 reported as error.
        req(OP_DIV, 3, 0);
        dispQ.push_back(24'hEEEEEE);
        key(8'h7A); key(8'hE0); key(8'h4A); key(8'h70);
        key(8'hE0); key(8'h5A);
        aluReply(0, 1'b1);
        chk("err_flag", oERR, 1'b1);
        key(8'h69);
        chk("err_ignores_digit", oDISP, 24'hEEEEEE);
        key(8'h76);
        chk("err_clear_disp", oDISP, 0);
        chk("err_clear_flag", oERR, 0);

        // Overflow: result above MAXVAL.
        req(OP_MUL, 1, 1);
        dispQ.push_back(24'hEEEEEE);
        key(8'h69); key(8'h7C); key(8'h69); key(8'h5A);
        aluReply(1000000, 1'b0);
        chk("ovf_err", oERR, 1'b1);
        key(8'h76);

        // Largest legal result, then a digit from RESULT.
        req(OP_ADD, 9, 0);
        dispQ.push_back(24'h999999);
        key(8'h7D); key(8'h79); key(8'h70); key(8'h5A);
        aluReply(999999, 1'b0);
        convLatency();
        key(8'h72);
        chk("result_digit", oDISP, 24'h000002);
        key(8'h76);

        // Seven digits, then keys while busy.
        repeat (7) key(8'h69);
        chk("seven_digits", oDISP, 24'h111111);
        req(OP_ADD, 111111, 2);
        dispQ.push_back(24'h111113);
        key(8'h79); key(8'h72); key(8'h5A);
        key(8'h76); key(8'h69);
        aluReply(111113, 1'b0);
        convLatency();
        key(8'h76);

        // Reset while waiting on the ALU.
        req(OP_ADD, 1, 1);
        key(8'h69); key(8'h79); key(8'h69); key(8'h5A);
        waitAluWait();
        dispQ.push_back(24'h000000);
        @(posedge clk); #1 iRST_n = 1'b0;
        @(posedge clk); #1 iRST_n = 1'b1;
        chk("rst_mid_busy", oBUSY, 1'b0);
        @(posedge clk); #1;
        alu.iALU_DONE   = 1'b1;
        alu.iALU_RESULT = 24'd2;
        @(posedge clk); #1;
        alu.iALU_DONE   = 1'b0;
        alu.iALU_RESULT = '0;
        repeat (WIDTH + 4) @(posedge clk);
        #1 chk("late_done_disp", oDISP, 0);
        chk("late_done_busy", oBUSY, 1'b0);

        chk("req_queue_empty", reqQ.size(), 0);
        chk("disp_queue_empty", dispQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
